// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the buffered fetch stage.
//   XLEN          : instruction / PC width carried in a queue entry
//   NOP_INSTR     : addi x0,x0,0, shown to decode whenever no entry is valid
//   fetch_entry_t : one prefetch queue entry {instr, pc, misalign}
// Optional feature macro: FETCH_MISALIGN_EN adds the per-entry misalign flag.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
`ifdef FETCH_MISALIGN_EN
    logic            misalign;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffered_if.sv
// fetch_buffered_if: imem read port plus the valid/ready decode handshake.
//   master : fetch stage side (drives imem request and head entry, takes rdata/Ready)
//   slave  : environment side (imem + decode)
// Signals:
//   imem_req_o / imem_addr_o / imem_rdata_i : synchronous-read imem port
//   Valid_o / Ready_i                        : decode handshake
//   Instr_o, PC_F, PCPlus4_F, A1_o/A2_o/A3_o : head entry and its register fields
//   Misalign_o                               : only with FETCH_MISALIGN_EN
interface fetch_buffered_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  imem_req_o;
  logic [DATA_WIDTH-1:0] imem_addr_o;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic                  Valid_o;
  logic                  Ready_i;
  logic [DATA_WIDTH-1:0] Instr_o;
  logic [DATA_WIDTH-1:0] PC_F;
  logic [DATA_WIDTH-1:0] PCPlus4_F;
  logic [4:0]            A1_o;
  logic [4:0]            A2_o;
  logic [4:0]            A3_o;
`ifdef FETCH_MISALIGN_EN
  logic                  Misalign_o;
`endif

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_rdata_i,
    output Valid_o, Instr_o, PC_F, PCPlus4_F, A1_o, A2_o, A3_o,
`ifdef FETCH_MISALIGN_EN
    output Misalign_o,
`endif
    input  Ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_rdata_i,
    input  Valid_o, Instr_o, PC_F, PCPlus4_F, A1_o, A2_o, A3_o,
`ifdef FETCH_MISALIGN_EN
    input  Misalign_o,
`endif
    output Ready_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch queue of fetch_entry_t.
//   clk, rst   : clock, asynchronous active-high reset
//   push/wdata : write an entry at the tail
//   pop        : drop the head entry
//   flush      : empty the queue (wins over push/pop)
//   rdata      : head entry (meaningful only when !empty)
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed through count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  pop_on_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty && !flush));

endmodule

// File: rtl/fetch_buffered.sv
// fetch_buffered: RISC-V fetch stage with PC generation, a synchronous-read
// imem port and a FIFO_DEPTH-entry prefetch queue towards decode.
//   clk, rst     : clock, asynchronous active-high reset
//   PCSrc_i      : redirect from Execute (taken branch/jump), highest priority
//   PCTargetE_i  : redirect target
//   bus (master) : imem port + decode handshake, see fetch_buffered_if
// Parameters: DATA_WIDTH (must equal fetch_pkg::XLEN), FIFO_DEPTH (power of 2,
// >= 2), RESET_PC.
// Optional feature macro FETCH_MISALIGN_EN: keeps target[1:0] in the PC and
// flags the entry fetched for a misaligned target via Misalign_o.
module fetch_buffered
  import fetch_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrc_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  fetch_buffered_if.master      bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] req_pc;
  logic                  inflight;
`ifdef FETCH_MISALIGN_EN
  logic                  req_mis;
`endif

  logic [DATA_WIDTH-1:0] pc_word;
  logic [DATA_WIDTH-1:0] pc_seq;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [AW+1:0]         credits_used;
  logic                  kill;
  logic                  req;
  logic                  push;
  logic                  pop;
  logic                  valid;

  fetch_entry_t          wdata;
  fetch_entry_t          head;
  logic [AW:0]           count;
  logic                  full;
  logic                  empty;

  assign pc_word = {pc[DATA_WIDTH-1:2], 2'b00};
  // Sequential fetch continues from the word boundary, so only the redirect
  // target itself can be misaligned.
  assign pc_seq  = pc_word + DATA_WIDTH'(4);

`ifdef FETCH_MISALIGN_EN
  assign redirect_pc = PCTargetE_i;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^PCTargetE_i[1:0];
  assign redirect_pc    = {PCTargetE_i[DATA_WIDTH-1:2], 2'b00};
`endif

  // Credits count queued entries plus the outstanding response; a pop in
  // this cycle only shows up through count next cycle.
  assign credits_used = {1'b0, count} + (AW+2)'(inflight);
  assign req          = !rst && !PCSrc_i && (credits_used < (AW+2)'(FIFO_DEPTH));

  // A redirect kills the response returning this cycle; with a one-cycle
  // imem the kill window is exactly the redirect cycle.
  assign kill  = PCSrc_i;
  assign push  = inflight && !kill;
  assign valid = !empty && !PCSrc_i;
  assign pop   = valid && bus.Ready_i;

  always_comb begin
    wdata          = '0;
    wdata.instr    = bus.imem_rdata_i;
    wdata.pc       = req_pc;
`ifdef FETCH_MISALIGN_EN
    wdata.misalign = req_mis;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      req_mis  <= 1'b0;
`endif
    end else if (PCSrc_i) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= req;
      if (req) begin
        req_pc  <= pc;
`ifdef FETCH_MISALIGN_EN
        req_mis <= (pc[1:0] != 2'b00);
`endif
        pc      <= pc_seq;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (PCSrc_i),
    .wdata (wdata),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc_word;
  assign bus.Valid_o     = valid;
  assign bus.Instr_o     = valid ? head.instr : NOP_INSTR;
  assign bus.PC_F        = valid ? head.pc : '0;
  assign bus.PCPlus4_F   = bus.PC_F + DATA_WIDTH'(4);
  assign bus.A1_o        = bus.Instr_o[19:15];
  assign bus.A2_o        = bus.Instr_o[24:20];
  assign bus.A3_o        = bus.Instr_o[11:7];
`ifdef FETCH_MISALIGN_EN
  assign bus.Misalign_o  = valid && head.misalign;
`endif

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_fetch_buffered.sv
module tb_fetch_buffered;
  import fetch_pkg::*;

  localparam int unsigned    DEPTH    = 4;
  localparam logic [31:0]    RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcsrc = 1'b0;
  logic [31:0] target = '0;

  fetch_buffered_if #(.DATA_WIDTH(32)) bus ();

  fetch_buffered #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PCSrc_i     (pcsrc),
    .PCTargetE_i (target),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a scrambled function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  initial bus.imem_rdata_i = '0;
  always @(posedge clk) begin
    if (bus.imem_req_o) bus.imem_rdata_i <= mem_word(bus.imem_addr_o);
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what decode should see, as a queue of entries.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    bit          mis;
  } ent_t;

  ent_t        q[$];
  bit          m_inflight;
  logic [31:0] m_ipc;
  logic [31:0] m_pc;

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic model_reset();
    q.delete();
    m_inflight = 0;
    m_ipc      = '0;
    m_pc       = RESET_PC;
  endtask

  task automatic do_cycle(input bit rdy, input bit pcs, input logic [31:0] tgt);
    bit          e_valid;
    bit          e_req;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    ent_t        e;
    @(negedge clk);
    bus.Ready_i = rdy;
    pcsrc       = pcs;
    target      = tgt;
    #1;
    e_valid = (q.size() > 0) && !pcs;
    e_instr = e_valid ? q[0].instr : NOP_INSTR;
    e_pc    = e_valid ? q[0].pc : 32'h0;
    e_req   = !pcs && ((q.size() + int'(m_inflight)) < DEPTH);
    check("valid",  {31'b0, bus.Valid_o}, {31'b0, e_valid});
    check("instr",  bus.Instr_o, e_instr);
    check("pc_f",   bus.PC_F, e_pc);
    check("pc4",    bus.PCPlus4_F, e_pc + 32'd4);
    check("a1",     {27'b0, bus.A1_o}, {27'b0, e_instr[19:15]});
    check("a2",     {27'b0, bus.A2_o}, {27'b0, e_instr[24:20]});
    check("a3",     {27'b0, bus.A3_o}, {27'b0, e_instr[11:7]});
    check("req",    {31'b0, bus.imem_req_o}, {31'b0, e_req});
    if (e_req) check("addr", bus.imem_addr_o, align(m_pc));
`ifdef FETCH_MISALIGN_EN
    check("misalign", {31'b0, bus.Misalign_o}, {31'b0, e_valid && q[0].mis});
`endif
    if (pcs) begin
      q.delete();
      m_inflight = 0;
`ifdef FETCH_MISALIGN_EN
      m_pc = tgt;
`else
      m_pc = align(tgt);
`endif
    end else begin
      if (e_valid && rdy) void'(q.pop_front());
      if (m_inflight) begin
        e.instr = mem_word(align(m_ipc));
        e.pc    = m_ipc;
        e.mis   = (m_ipc[1:0] != 2'b00);
        q.push_back(e);
      end
      m_inflight = e_req;
      if (e_req) begin
        m_ipc = m_pc;
        m_pc  = align(m_pc) + 32'd4;
      end
    end
  endtask

  // Asserts reset between edges and checks the asynchronous clear, then
  // releases it just after a rising edge so the next do_cycle is cycle 0.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_valid", {31'b0, bus.Valid_o}, 32'd0);
    check("rst_instr", bus.Instr_o, NOP_INSTR);
    check("rst_pc_f",  bus.PC_F, 32'h0);
    check("rst_req",   {31'b0, bus.imem_req_o}, 32'd0);
`ifdef FETCH_MISALIGN_EN
    check("rst_misalign", {31'b0, bus.Misalign_o}, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.Ready_i = 1'b0;
    model_reset();

    // Streaming with decode always ready.
    do_reset();
    repeat (12) do_cycle(1'b1, 1'b0, '0);

    // Decode stalled from reset: queue fills, requests stop, then drain.
    do_reset();
    repeat (8) do_cycle(1'b0, 1'b0, '0);
    repeat (8) do_cycle(1'b1, 1'b0, '0);

    // Redirect with three queued and one in flight.
    do_reset();
    repeat (4) do_cycle(1'b0, 1'b0, '0);
    do_cycle(1'b0, 1'b1, 32'h0000_0100);
    repeat (6) do_cycle(1'b1, 1'b0, '0);

    // Redirect in the same cycle decode would pop.
    repeat (3) do_cycle(1'b1, 1'b0, '0);
    do_cycle(1'b1, 1'b1, 32'h0000_0200);
    repeat (4) do_cycle(1'b1, 1'b0, '0);

    // Back-to-back redirects, last one wins.
    do_cycle(1'b1, 1'b1, 32'h0000_0300);
    do_cycle(1'b1, 1'b1, 32'h0000_0400);
    repeat (4) do_cycle(1'b1, 1'b0, '0);

    // Misaligned target.
    do_cycle(1'b1, 1'b1, 32'h0000_0102);
    repeat (6) do_cycle(1'b1, 1'b0, '0);

    // PC wrap at 2^32.
    do_cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (6) do_cycle(1'b1, 1'b0, '0);

    // Random traffic, with occasional mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      bit          rdy;
      bit          pcs;
      logic [31:0] tgt;
      rdy = ($urandom_range(0, 99) < 65);
      pcs = ($urandom_range(0, 99) < 6);
      tgt = $urandom & 32'h0000_3FFF;
      if (i % 133 == 132) do_reset();
      do_cycle(rdy, pcs, tgt);
    end

    // Reset while a response is in flight.
    repeat (3) do_cycle(1'b1, 1'b0, '0);
    do_reset();
    repeat (5) do_cycle(1'b1, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
